movimentacao_servo: RTL and testbench



---
 rtl/servo_pkg.sv | 39 +++
 rtl/contador_espera.sv | 41 ++++
 rtl/movimentacao_servo.sv | 135 +++++++++++++
 tb/tb_movimentacao_servo.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared types and position helpers for the servo position sequencer.
// SERVO_VAIVEM_EN selects the ping-pong sweep; the sawtooth helper serves the default build.
package servo_pkg;

   typedef logic [1:0] estado_t;
   localparam estado_t REPOUSO = 2'd0;
   localparam estado_t INICIO  = 2'd1;
   localparam estado_t CONTA   = 2'd2;
   localparam estado_t PAUSADO = 2'd3;

   typedef logic [1:0] posicao_t;
   localparam posicao_t POS_REPOUSO = 2'b00;
   localparam posicao_t POS_MIN     = 2'b01;
   localparam posicao_t POS_MED     = 2'b10;
   localparam posicao_t POS_MAX     = 2'b11;

   // Sawtooth: 01 -> 10 -> 11 -> 01
   function automatic posicao_t proxima_serra(input posicao_t atual);
      posicao_t prox;
      if (atual == POS_MAX) begin
         prox = POS_MIN;
      end else begin
         prox = atual + 2'd1;
      end
      return prox;
   endfunction

   // Ping-pong: direction register decides whether to step up or down
   function automatic posicao_t proxima_vaivem(input posicao_t atual, input logic descendo);
      posicao_t prox;
      if (descendo) begin
         prox = atual - 2'd1;
      end else begin
         prox = atual + 2'd1;
      end
      return prox;
   endfunction

endpackage

// File: rtl/contador_espera.sv
// Dwell counter for the servo sequencer: counts 0..T_ESPERA-1 while enabled, clear wins.
// Raises terminal while sitting on the last count; never runs past it.
module contador_espera #(
   parameter int unsigned T_ESPERA = 50_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic limpar,
   input  logic habilitar,
   output logic terminal
);

   localparam int unsigned LARGURA = (T_ESPERA > 1) ? $clog2(T_ESPERA) : 1;
   localparam logic [LARGURA-1:0] ULTIMO = LARGURA'(T_ESPERA - 1);

   logic [LARGURA-1:0] conta_q, conta_d;

   assign terminal = (conta_q == ULTIMO);

   always_comb begin
      conta_d = conta_q;
      if (limpar) begin
         conta_d = '0;
      end else if (habilitar) begin
         if (terminal) begin
            conta_d = '0;
         end else begin
            conta_d = conta_q + LARGURA'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         conta_q <= '0;
      end else begin
         conta_q <= conta_d;
      end
   end

endmodule

// File: rtl/movimentacao_servo.sv
// Servo position sequencer: sweeps posicao through 01/10/11 with a fixed dwell, parks at 00.
// Define SERVO_VAIVEM_EN for the ping-pong sweep; default build is the sawtooth sweep.
module movimentacao_servo #(
   parameter int unsigned T_ESPERA = 50_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ligar,
   input  logic       pausar,
   output logic [1:0] posicao,
   output logic       nova_posicao,
   output logic       fim_ciclo,
   output logic [1:0] db_estado
);

   import servo_pkg::*;

   estado_t  estado_q, estado_d;
   posicao_t posicao_q, posicao_d;
   posicao_t proxima;
   logic     nova_q, nova_d;
   logic     fim_q, fim_d;
   logic     limpar, habilitar, terminal;

`ifdef SERVO_VAIVEM_EN
   logic descendo_q, descendo_d;

   assign proxima = proxima_vaivem(posicao_q, descendo_q);

   // Direction flips on arrival at either end of the sweep
   always_comb begin
      descendo_d = descendo_q;
      if (limpar) begin
         descendo_d = 1'b0;
      end else if (habilitar && terminal) begin
         if (proxima == POS_MAX) begin
            descendo_d = 1'b1;
         end else if (proxima == POS_MIN) begin
            descendo_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         descendo_q <= 1'b0;
      end else begin
         descendo_q <= descendo_d;
      end
   end
`else
   assign proxima = proxima_serra(posicao_q);
`endif

   contador_espera #(
      .T_ESPERA (T_ESPERA)
   ) u_contador (
      .clock     (clock),
      .reset     (reset),
      .limpar    (limpar),
      .habilitar (habilitar),
      .terminal  (terminal)
   );

   always_comb begin
      estado_d  = estado_q;
      posicao_d = posicao_q;
      nova_d    = 1'b0;
      fim_d     = 1'b0;
      limpar    = 1'b0;
      habilitar = 1'b0;
      // Dropping ligar parks immediately from any active state, with no pulses
      if (estado_q != REPOUSO && !ligar) begin
         estado_d  = REPOUSO;
         posicao_d = POS_REPOUSO;
         limpar    = 1'b1;
      end else begin
         case (estado_q)
            REPOUSO: begin
               posicao_d = POS_REPOUSO;
               limpar    = 1'b1;
               if (ligar) begin
                  estado_d = INICIO;
               end
            end
            INICIO: begin
               posicao_d = POS_MIN;
               nova_d    = 1'b1;
               limpar    = 1'b1;
               estado_d  = CONTA;
            end
            CONTA: begin
               if (pausar) begin
                  estado_d = PAUSADO;
               end else begin
                  habilitar = 1'b1;
                  if (terminal) begin
                     posicao_d = proxima;
                     nova_d    = 1'b1;
                     fim_d     = (proxima == POS_MIN);
                  end
               end
            end
            PAUSADO: begin
               if (!pausar) begin
                  estado_d = CONTA;
               end
            end
            default: begin
               estado_d = REPOUSO;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q  <= REPOUSO;
         posicao_q <= POS_REPOUSO;
         nova_q    <= 1'b0;
         fim_q     <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         posicao_q <= posicao_d;
         nova_q    <= nova_d;
         fim_q     <= fim_d;
      end
   end

   assign posicao      = posicao_q;
   assign nova_posicao = nova_q;
   assign fim_ciclo    = fim_q;
   assign db_estado    = estado_q;

endmodule

// File: tb/tb_movimentacao_servo.sv
// Self-checking bench for movimentacao_servo with T_ESPERA=4, directed plus random stimulus.
// The reference model walks a position list; SERVO_VAIVEM_EN picks which list.
module tb_movimentacao_servo;

   localparam int unsigned T = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ligar = 1'b0;
   logic       pausar = 1'b0;
   logic [1:0] posicao;
   logic       nova_posicao;
   logic       fim_ciclo;
   logic [1:0] db_estado;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: 0 parked, 1 starting, 2 running, 3 paused
   int         m_mode;
   int         m_idx;
   int         m_elapsed;
   logic [1:0] m_pos;
   logic       m_nova;
   logic       m_fim;
   int         seq [$];

   movimentacao_servo #(
      .T_ESPERA (T)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .ligar        (ligar),
      .pausar       (pausar),
      .posicao      (posicao),
      .nova_posicao (nova_posicao),
      .fim_ciclo    (fim_ciclo),
      .db_estado    (db_estado)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode    = 0;
      m_idx     = 0;
      m_elapsed = 0;
      m_pos     = 2'b00;
      m_nova    = 1'b0;
      m_fim     = 1'b0;
   endtask

   task automatic model_step(input logic l, input logic p);
      m_nova = 1'b0;
      m_fim  = 1'b0;
      if (!l) begin
         model_reset();
      end else begin
         case (m_mode)
            0: m_mode = 1;
            1: begin
               m_idx     = 0;
               m_pos     = 2'(seq[0]);
               m_elapsed = 0;
               m_nova    = 1'b1;
               m_mode    = 2;
            end
            2: begin
               if (p) begin
                  m_mode = 3;
               end else if (m_elapsed == int'(T) - 1) begin
                  m_idx     = (m_idx + 1) % seq.size();
                  m_pos     = 2'(seq[m_idx]);
                  m_nova    = 1'b1;
                  m_fim     = (m_idx == 0);
                  m_elapsed = 0;
               end else begin
                  m_elapsed++;
               end
            end
            default: begin
               if (!p) m_mode = 2;
            end
         endcase
      end
   endtask

   task automatic compare_all();
      check_eq("posicao", 32'(posicao), 32'(m_pos));
      check_eq("nova_posicao", 32'(nova_posicao), 32'(m_nova));
      check_eq("fim_ciclo", 32'(fim_ciclo), 32'(m_fim));
      check_eq("db_estado", 32'(db_estado), 32'(m_mode));
   endtask

   task automatic cycle(input logic l, input logic p);
      @(negedge clock);
      ligar  = l;
      pausar = p;
      @(posedge clock);
      model_step(l, p);
      #1;
      compare_all();
   endtask

   initial begin
      bit found;
      logic pz;
`ifdef SERVO_VAIVEM_EN
      seq = '{1, 2, 3, 2};
`else
      seq = '{1, 2, 3};
`endif
      model_reset();
      #1;
      compare_all();
      @(negedge clock);
      reset = 1'b0;

      // Idle with ligar low, then a full sweep and a half
      repeat (3) cycle(1'b0, 1'b0);
      repeat (22) cycle(1'b1, 1'b0);

      // Asynchronous reset while sitting at 11
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle(1'b1, 1'b0);
         if (m_pos == 2'b11) found = 1'b1;
      end
      check_eq("reach_pos_11", 32'(found), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(negedge clock);
      reset = 1'b0;
      ligar = 1'b0;
      repeat (4) cycle(1'b0, 1'b0);

      // Pause for 10 cycles after 2 cycles in position 10
      cycle(1'b1, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle(1'b1, 1'b0);
         if (m_pos == 2'b10 && m_nova) found = 1'b1;
      end
      check_eq("reach_pos_10", 32'(found), 32'd1);
      repeat (2) cycle(1'b1, 1'b0);
      repeat (10) cycle(1'b1, 1'b1);
      repeat (8) cycle(1'b1, 1'b0);

      // Drop ligar exactly on the terminal count
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle(1'b1, 1'b0);
         if (m_mode == 2 && m_elapsed == int'(T) - 1) found = 1'b1;
      end
      check_eq("reach_terminal", 32'(found), 32'd1);
      cycle(1'b0, 1'b0);

      // Restart after park: full dwell from 01 going up
      repeat (16) cycle(1'b1, 1'b0);

      // Random ligar/pausar with mostly-on enable and sticky pause
      pz = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 7) == 0) pz = ~pz;
         cycle(($urandom_range(0, 24) != 0), pz);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
